uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with a built-in transmit FIFO. It has configurable data width, parity mode and stop-bit count, and streams frames back-to-back with no idle gap. It is the general-purpose serial output for testbench examples and debug/PMU readout paths, and it accepts words through a valid/ready handshake.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx_fifo_if.sv | 24 ++
 rtl/uart_sync_fifo.sv | 51 +++++
 rtl/uart_tx_fifo.sv | 134 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } uart_tx_state_t;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } uart_parity_t;

  function automatic int cycles_per_bit(input int clk_mhz, input int baud);
    return (clk_mhz * 1000000) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Word-enqueue handshake for the UART transmitter.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8
) ();

  // A word transfers on a rising clk edge where tx_data_valid && tx_data_ready.
  // The master holds tx_data stable while valid is high; ready never depends on valid.
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_data_valid;
  logic                 tx_data_ready;

  modport master (
    output tx_data,
    output tx_data_valid,
    input  tx_data_ready
  );

  modport slave (
    input  tx_data,
    input  tx_data_valid,
    output tx_data_ready
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Generic single-clock FIFO; head word is visible combinationally on rd_data.
module uart_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by an internal FIFO; frames stream back-to-back.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FRE    = 50,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  uart_tx_fifo_if.slave                 tx_if,
  output logic                          tx_pin,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output uart_tx_state_t                state_dbg
);

  localparam int                CYCLE     = cycles_per_bit(CLK_FRE, BAUD_RATE);
  localparam int                CW        = $clog2(CYCLE);
  localparam int                DW        = $clog2(DATA_BITS);
  localparam logic [CW-1:0]     BIT_LAST  = CW'(CYCLE - 1);
  localparam logic [DW-1:0]     DATA_LAST = DW'(DATA_BITS - 1);
  localparam logic              STOP_LAST = (STOP_BITS == 2);

  uart_tx_state_t       state;
  logic [CW-1:0]        bit_cnt;
  logic [DW-1:0]        data_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shift_q;
  logic                 parity_q;
  logic                 init_done;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] head;
  logic                 pop;
  logic                 bit_end;
  logic                 frame_end;

  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
    return (PARITY == int'(PAR_ODD)) ? ~(^d) : (^d);
  endfunction

  assign bit_end   = (bit_cnt == BIT_LAST);
  assign frame_end = (state == S_STOP) && bit_end && (stop_cnt == STOP_LAST);
  // Pop either from idle or on the last stop-bit clock, so frames abut with no gap.
  assign pop       = !fifo_empty && ((state == S_IDLE) || frame_end);

  assign tx_if.tx_data_ready = init_done && !fifo_full;
  assign tx_busy             = (state != S_IDLE) || !fifo_empty;
  assign state_dbg           = state;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (tx_if.tx_data_valid && tx_if.tx_data_ready),
    .wr_data (tx_if.tx_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // tx_pin is the registered image of the current state, one clock behind it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      data_cnt  <= '0;
      stop_cnt  <= 1'b0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tx_pin    <= 1'b1;
      init_done <= 1'b0;
    end else begin
      init_done <= 1'b1;
      bit_cnt   <= ((state == S_IDLE) || bit_end) ? '0 : bit_cnt + CW'(1);
      if (pop) begin
        shift_q  <= head;
        parity_q <= calc_parity(head);
      end
      case (state)
        S_IDLE: begin
          tx_pin <= 1'b1;
          if (pop) state <= S_START;
        end
        S_START: begin
          tx_pin <= 1'b0;
          if (bit_end) begin
            state    <= S_DATA;
            data_cnt <= '0;
          end
        end
        S_DATA: begin
          tx_pin <= shift_q[0];
          if (bit_end) begin
            shift_q <= shift_q >> 1;
            if (data_cnt == DATA_LAST) begin
              state    <= (PARITY != int'(PAR_NONE)) ? S_PARITY : S_STOP;
              stop_cnt <= 1'b0;
            end else begin
              data_cnt <= data_cnt + DW'(1);
            end
          end
        end
        S_PARITY: begin
          tx_pin <= parity_q;
          if (bit_end) begin
            state    <= S_STOP;
            stop_cnt <= 1'b0;
          end
        end
        S_STOP: begin
          tx_pin <= 1'b1;
          if (bit_end) begin
            if (stop_cnt == STOP_LAST) state <= pop ? S_START : S_IDLE;
            else                       stop_cnt <= 1'b1;
          end
        end
        default: begin
          state  <= S_IDLE;
          tx_pin <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed and streaming checks of uart_tx_fifo at 10 clocks per bit.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int CYC = 10;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int lo;
  logic [7:0] w3 [6];
  logic [7:0] w4 [4];
  logic [7:0] exp_q [$];

  uart_tx_fifo_if #(.DATA_BITS(8)) a_if ();
  uart_tx_fifo_if #(.DATA_BITS(7)) b_if ();
  uart_tx_fifo_if #(.DATA_BITS(7)) c_if ();

  logic           a_pin, b_pin, c_pin;
  logic           a_busy, b_busy, c_busy;
  logic [2:0]     a_lvl, b_lvl, c_lvl;
  uart_tx_state_t a_st, b_st, c_st;

  uart_tx_fifo #(.CLK_FRE(1), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .tx_if(a_if), .tx_pin(a_pin), .tx_busy(a_busy),
    .fifo_level(a_lvl), .state_dbg(a_st));

  uart_tx_fifo #(.CLK_FRE(1), .BAUD_RATE(100000), .DATA_BITS(7), .PARITY(2),
                 .STOP_BITS(2), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .rst(rst), .tx_if(b_if), .tx_pin(b_pin), .tx_busy(b_busy),
    .fifo_level(b_lvl), .state_dbg(b_st));

  uart_tx_fifo #(.CLK_FRE(1), .BAUD_RATE(100000), .DATA_BITS(7), .PARITY(1),
                 .STOP_BITS(2), .FIFO_DEPTH(4)) u_c (
    .clk(clk), .rst(rst), .tx_if(c_if), .tx_pin(c_pin), .tx_busy(c_busy),
    .fifo_level(c_lvl), .state_dbg(c_st));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic pin_of(input int i);
    return (i == 0) ? a_pin : ((i == 1) ? b_pin : c_pin);
  endfunction

  function automatic logic busy_of(input int i);
    return (i == 0) ? a_busy : ((i == 1) ? b_busy : c_busy);
  endfunction

  // Called at the negedge after the first start-bit clock; samples every clock of the frame.
  task automatic check_frame(input int i, input logic [8:0] d, input int nd, input int par,
                             input int stops, input bit last, input string tag);
    logic [11:0]    bits;
    logic [CYC-1:0] got;
    logic           p;
    int             nb;
    bits = '0;
    p    = 1'b0;
    nb   = 1;
    for (int k = 0; k < nd; k++) begin
      bits[nb] = d[k];
      p        = p ^ d[k];
      nb++;
    end
    if (par != 0) begin
      bits[nb] = (par == 1) ? ~p : p;
      nb++;
    end
    for (int k = 0; k < stops; k++) begin
      bits[nb] = 1'b1;
      nb++;
    end
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < CYC; c++) begin
        got[c] = pin_of(i);
        if (last && (b == nb - 1) && (c >= CYC - 2))
          chk({tag, "_busy"}, 32'(busy_of(i)), 32'(c == CYC - 2));
        @(negedge clk);
      end
      chk($sformatf("%s_bit%0d", tag, b), 32'(got), 32'({CYC{bits[b]}}));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    a_if.tx_data = '0; a_if.tx_data_valid = 1'b0;
    b_if.tx_data = '0; b_if.tx_data_valid = 1'b0;
    c_if.tx_data = '0; c_if.tx_data_valid = 1'b0;
    w3 = '{8'h3C, 8'h81, 8'hF0, 8'h0F, 8'h66, 8'h99};
    w4 = '{8'hC3, 8'h5A, 8'h01, 8'hE7};

    // reset values
    @(negedge clk);
    chk("rst_pin",   32'(a_pin), 1);
    chk("rst_ready", 32'(a_if.tx_data_ready), 0);
    chk("rst_busy",  32'(a_busy), 0);
    chk("rst_level", 32'(a_lvl), 0);
    chk("rst_state", 32'(a_st), 32'(S_IDLE));
    chk("rst_b_state", 32'(b_st), 32'(S_IDLE));
    chk("rst_c_pin", 32'(c_pin), 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_before_clk", 32'(a_if.tx_data_ready), 0);
    @(negedge clk);
    chk("ready_after_clk", 32'(a_if.tx_data_ready), 1);

    // 8N1 single frame
    a_if.tx_data = 8'hA5; a_if.tx_data_valid = 1'b1;
    @(negedge clk);
    a_if.tx_data_valid = 1'b0;
    chk("t1_level_push", 32'(a_lvl), 1);
    chk("t1_pin_push",   32'(a_pin), 1);
    @(negedge clk);
    chk("t1_level_pop", 32'(a_lvl), 0);
    chk("t1_state_pop", 32'(a_st), 32'(S_START));
    chk("t1_pin_pop",   32'(a_pin), 1);
    chk("t1_busy_pop",  32'(a_busy), 1);
    @(negedge clk);
    check_frame(0, 9'h0A5, 8, 0, 1, 1'b1, "t1");
    chk("t1_end_state", 32'(a_st), 32'(S_IDLE));
    chk("t1_end_pin",   32'(a_pin), 1);

    // 7E2 then 7O2
    b_if.tx_data = 7'h55; b_if.tx_data_valid = 1'b1;
    @(negedge clk);
    b_if.tx_data_valid = 1'b0;
    chk("t2e_level", 32'(b_lvl), 1);
    @(negedge clk);
    @(negedge clk);
    check_frame(1, 9'h055, 7, 2, 2, 1'b1, "t2e");
    chk("t2e_end_state", 32'(b_st), 32'(S_IDLE));
    c_if.tx_data = 7'h55; c_if.tx_data_valid = 1'b1;
    @(negedge clk);
    c_if.tx_data_valid = 1'b0;
    chk("t2o_level", 32'(c_lvl), 1);
    @(negedge clk);
    @(negedge clk);
    check_frame(2, 9'h055, 7, 1, 2, 1'b1, "t2o");
    chk("t2o_end_state", 32'(c_st), 32'(S_IDLE));

    // depth-4 overflow: six back-to-back pushes, sixth rejected
    fork
      begin
        a_if.tx_data_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
          a_if.tx_data = w3[k];
          chk($sformatf("t3_ready%0d", k), 32'(a_if.tx_data_ready), 32'(k < 5));
          @(negedge clk);
        end
        a_if.tx_data_valid = 1'b0;
        chk("t3_level_full", 32'(a_lvl), 4);
      end
      begin
        repeat (3) @(negedge clk);
        for (int k = 0; k < 5; k++)
          check_frame(0, {1'b0, w3[k]}, 8, 0, 1, k == 4, $sformatf("t3_f%0d", k));
      end
    join
    lo = 0;
    repeat (30) begin
      if (a_pin !== 1'b1) lo++;
      @(negedge clk);
    end
    chk("t3_no_extra_frame", 32'(lo), 0);
    chk("t3_level_end", 32'(a_lvl), 0);

    // push on the pop edge at level 2
    fork
      begin
        a_if.tx_data_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
          a_if.tx_data = w4[k];
          @(negedge clk);
        end
        a_if.tx_data_valid = 1'b0;
        repeat (98) @(negedge clk);
        chk("t4_level_before", 32'(a_lvl), 2);
        chk("t4_state_before", 32'(a_st), 32'(S_STOP));
        a_if.tx_data = w4[3]; a_if.tx_data_valid = 1'b1;
        @(negedge clk);
        a_if.tx_data_valid = 1'b0;
        chk("t4_level_after", 32'(a_lvl), 2);
        chk("t4_state_after", 32'(a_st), 32'(S_START));
      end
      begin
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++)
          check_frame(0, {1'b0, w4[k]}, 8, 0, 1, k == 3, $sformatf("t4_f%0d", k));
      end
    join

    // reset in the middle of the data bits
    a_if.tx_data = 8'h00; a_if.tx_data_valid = 1'b1;
    @(negedge clk);
    a_if.tx_data = 8'h0F;
    @(negedge clk);
    a_if.tx_data_valid = 1'b0;
    repeat (14) @(negedge clk);
    chk("t5_pin_mid_data", 32'(a_pin), 0);
    chk("t5_state_mid",    32'(a_st), 32'(S_DATA));
    chk("t5_level_mid",    32'(a_lvl), 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_pin_async", 32'(a_pin), 1);
    chk("t5_level_rst", 32'(a_lvl), 0);
    chk("t5_ready_rst", 32'(a_if.tx_data_ready), 0);
    chk("t5_state_rst", 32'(a_st), 32'(S_IDLE));
    chk("t5_busy_rst",  32'(a_busy), 0);
    @(negedge clk);
    rst = 1'b0;
    lo = 0;
    repeat (150) begin
      if (a_pin !== 1'b1) lo++;
      @(negedge clk);
    end
    chk("t5_no_resume", 32'(lo), 0);
    chk("t5_level_end", 32'(a_lvl), 0);
    chk("t5_busy_end",  32'(a_busy), 0);

    // random 200-word stream against a receiver model
    fork
      begin
        for (int k = 0; k < 200; k++) begin
          int         gap;
          int         guard;
          logic [7:0] d;
          gap = $urandom_range(0, 12);
          repeat (gap) @(negedge clk);
          d = 8'($urandom_range(0, 255));
          a_if.tx_data = d;
          a_if.tx_data_valid = 1'b1;
          guard = 0;
          while (a_if.tx_data_ready !== 1'b1 && guard < 1000) begin
            @(negedge clk);
            guard++;
          end
          if (guard >= 1000) begin
            chk("t6_ready_timeout", 32'(guard), 0);
            a_if.tx_data_valid = 1'b0;
            break;
          end
          exp_q.push_back(d);
          @(negedge clk);
          a_if.tx_data_valid = 1'b0;
        end
      end
      begin
        for (int k = 0; k < 200; k++) begin
          int         idle;
          logic [7:0] r;
          logic       sb;
          logic       stp;
          idle = 0;
          while (a_pin !== 1'b0 && idle < 5000) begin
            @(negedge clk);
            idle++;
          end
          if (idle >= 5000) begin
            chk("t6_rx_timeout", 32'(idle), 0);
            break;
          end
          repeat (CYC / 2) @(negedge clk);
          sb = a_pin;
          for (int b = 0; b < 8; b++) begin
            repeat (CYC) @(negedge clk);
            r[b] = a_pin;
          end
          repeat (CYC) @(negedge clk);
          stp = a_pin;
          chk("t6_framing", 32'({sb, stp}), 32'(2'b01));
          if (exp_q.size() == 0) chk("t6_unexpected_word", 32'(r), 32'h100);
          else                   chk("t6_word", 32'(r), 32'(exp_q.pop_front()));
        end
      end
    join
    chk("t6_queue_drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
